// File: rtl/e2prom_rw_tester.sv
// e2prom_rw_tester: writes the address-derived byte pattern to the E2PROM, reads it back and reports pass/fail once after reset
module e2prom_rw_tester #(
  parameter logic [15:0] BYTE_NUM     = 16'd256,
  parameter logic [15:0] WR_WAIT_TIME = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic [7:0]  i2c_data_r,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        rw_done,
  output logic        rw_result
);
  typedef enum logic [2:0] {WR_REQ, WR_BUSY, WR_GAP, RD_REQ, RD_BUSY, FINISH} state_t;
  state_t state, next;
  logic [15:0] addr, cnt;
  logic last, gap_end, rd_ok, pass, enter_fin;
  assign last      = addr == BYTE_NUM - 16'd1;
  assign gap_end   = cnt == WR_WAIT_TIME - 16'd1;
  assign rd_ok     = !i2c_ack && i2c_data_r == addr[7:0];
  assign enter_fin = next == FINISH && state != FINISH;
  // The reset state is WR_REQ, so exec is gated to stay low while reset is held
  assign i2c_exec   = rst_n && (state == WR_REQ || state == RD_REQ);
  assign i2c_rh_wl  = state == RD_REQ || state == RD_BUSY;
  assign i2c_addr   = addr;
  assign i2c_data_w = addr[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WR_REQ;
    else state <= next;
  always_comb begin
    next = state;
    pass = 1'b0;
    case (state)
      WR_REQ:  next = WR_BUSY;
      WR_BUSY: if (i2c_done) next = i2c_ack ? FINISH : WR_GAP;
      WR_GAP:  if (gap_end) next = last ? RD_REQ : WR_REQ;
      RD_REQ:  next = RD_BUSY;
      RD_BUSY: if (i2c_done) begin
        next = rd_ok && !last ? RD_REQ : FINISH;
        pass = rd_ok && last;
      end
      default: next = FINISH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr      <= 16'd0;
      cnt       <= 16'd0;
      rw_done   <= 1'b0;
      rw_result <= 1'b0;
    end else begin
      cnt     <= state == WR_GAP && !gap_end ? cnt + 16'd1 : 16'd0;
      addr    <= state == WR_GAP && next == RD_REQ ? 16'd0 :
                 (state == WR_GAP && next == WR_REQ) || (state == RD_BUSY && next == RD_REQ) ? addr + 16'd1 : addr;
      rw_done <= enter_fin;
      if (enter_fin) rw_result <= pass;
    end
endmodule

// File: tb/tb_e2prom_rw_tester.sv
// tb_e2prom_rw_tester: randomized-latency E2PROM slave model checking the tester's transaction sequence and verdict
module tb_e2prom_rw_tester;
  logic clk = 0, rst_n = 0, sel = 0;
  logic i2c_done = 0, i2c_ack = 0;
  logic [7:0] i2c_data_r = 0;
  logic a_exec, a_rw, a_done, a_res, b_exec, b_rw, b_done, b_res;
  logic [15:0] a_addr, b_addr;
  logic [7:0] a_dw, b_dw;
  logic rst_a, rst_b, i2c_exec, i2c_rh_wl, rw_done, rw_result;
  logic [15:0] i2c_addr;
  logic [7:0] i2c_data_w;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  // The unselected instance is held in reset so shared inputs never disturb it
  assign rst_a      = sel ? 1'b0 : rst_n;
  assign rst_b      = sel ? rst_n : 1'b0;
  assign i2c_exec   = sel ? b_exec : a_exec;
  assign i2c_rh_wl  = sel ? b_rw : a_rw;
  assign i2c_addr   = sel ? b_addr : a_addr;
  assign i2c_data_w = sel ? b_dw : a_dw;
  assign rw_done    = sel ? b_done : a_done;
  assign rw_result  = sel ? b_res : a_res;
  e2prom_rw_tester #(.BYTE_NUM(16'd4), .WR_WAIT_TIME(16'd10)) dut_a (
    .clk(clk), .rst_n(rst_a), .i2c_exec(a_exec), .i2c_rh_wl(a_rw), .i2c_addr(a_addr),
    .i2c_data_w(a_dw), .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .rw_done(a_done), .rw_result(a_res));
  e2prom_rw_tester #(.BYTE_NUM(16'd1), .WR_WAIT_TIME(16'd1)) dut_b (
    .clk(clk), .rst_n(rst_b), .i2c_exec(b_exec), .i2c_rh_wl(b_rw), .i2c_addr(b_addr),
    .i2c_data_w(b_dw), .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .rw_done(b_done), .rw_result(b_res));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // kind: 0 clean pass, 1 bad read data at fa, 2 write NACK at fa, 3 reset during read of fa
  task automatic run_test(input int kind, input int fa, input bit do_rst);
    int q_rw[$], q_a[$];
    int bn, wt, idx = 0, lat = 0, cyc = 0, fin_cyc = -1, done_cyc = -100, gap_ref = -1, ndone = 0, rst_at = -1, cur_a = 0;
    bit pend = 0, cur_rd = 0, exp_pass, aborted = 0;
    logic [7:0] mem [int];
    bn = sel ? 1 : 4;
    wt = sel ? 1 : 10;
    for (int a = 0; a < bn; a++) begin
      q_rw.push_back(0); q_a.push_back(a);
      if (kind == 2 && a == fa) break;
    end
    if (kind != 2)
      for (int a = 0; a < bn; a++) begin
        q_rw.push_back(1); q_a.push_back(a);
        if ((kind == 1 || kind == 3) && a == fa) break;
      end
    exp_pass = kind == 0;
    if (do_rst) begin
      rst_n = 0; i2c_done = 0; i2c_ack = 0;
      repeat (2) @(negedge clk);
      check("rst_outs", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, rw_done, rw_result}, 0);
      @(posedge clk); #1 rst_n = 1;
    end
    while (cyc < 3000 && !aborted && !(fin_cyc >= 0 && cyc > fin_cyc + 20)) begin
      @(negedge clk); cyc++;
      i2c_done = 0; i2c_ack = 0; i2c_data_r = 8'($urandom);
      if (cyc == rst_at) begin
        #2 rst_n = 0;
        #1 check("async_rst", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, rw_done, rw_result}, 0);
        @(negedge clk);
        check("in_rst", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, rw_done, rw_result}, 0);
        @(posedge clk); #1 rst_n = 1;
        aborted = 1;
      end else begin
        if (rw_done) begin
          ndone++;
          check("done_lat", cyc - done_cyc, 1);
          check("done_txcnt", idx, q_a.size());
          check("result", rw_result, exp_pass);
          fin_cyc = cyc;
        end else check("result_hold", rw_result, fin_cyc >= 0 ? exp_pass : 1'b0);
        if (i2c_exec) begin
          check("exec_idle", pend, 0);
          check("exec_expected", idx < q_a.size(), 1);
          if (idx < q_a.size()) begin
            check("rh_wl", i2c_rh_wl, q_rw[idx]);
            check("addr", i2c_addr, q_a[idx]);
            if (idx == 0) check("first_exec", cyc, 1);
            if (!q_rw[idx]) begin
              check("data_w", i2c_data_w, q_a[idx] & 255);
              mem[q_a[idx]] = i2c_data_w;
            end
            if (gap_ref >= 0) check("gap", cyc - gap_ref, wt);
            else if (q_rw[idx] && idx > 0 && q_rw[idx-1] == 1) check("rd_b2b", cyc - done_cyc, 1);
            cur_rd = q_rw[idx] != 0; cur_a = q_a[idx];
            pend = 1; lat = $urandom_range(1, 4); gap_ref = -1; idx++;
            if (kind == 3 && cur_rd && cur_a == fa) rst_at = cyc + 1;
          end
        end else if (pend) begin
          check("hold_rw", i2c_rh_wl, cur_rd);
          check("hold_addr", i2c_addr, cur_a);
          if (!cur_rd) check("hold_data", i2c_data_w, cur_a & 255);
          lat--;
          if (lat == 0) begin
            pend = 0; done_cyc = cyc; i2c_done = 1;
            i2c_ack = kind == 2 && !cur_rd && cur_a == fa;
            if (cur_rd) i2c_data_r = (kind == 1 && cur_a == fa) ? 8'h55 : mem[cur_a];
            gap_ref = (!cur_rd && !i2c_ack) ? cyc + 1 : -1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          i2c_done = 1; i2c_ack = 1'($urandom);
        end
      end
    end
    i2c_done = 0; i2c_ack = 0;
    if (!aborted) check("done_pulses", ndone, 1);
  endtask
  initial begin
    run_test(0, 0, 1);
    run_test(1, 2, 1);
    run_test(2, 1, 1);
    run_test(3, 2, 1);
    run_test(0, 0, 0);
    repeat (3) run_test($urandom_range(0, 2), $urandom_range(0, 3), 1);
    rst_n = 0;
    @(negedge clk) sel = 1;
    run_test(0, 0, 1);
    run_test(1, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
